aidc_lite_decomp_zrle: RTL and testbench

//  Zero-run-length decompressor; inverse of the ZRLE compressor on the compression side.

---
 rtl/aidc_lite_zrle_pkg.sv | 24 ++
 rtl/aidc_lite_decomp_zrle_if.sv | 17 +
 rtl/aidc_lite_zrle_bitbuf.sv | 62 ++++++
 rtl/aidc_lite_decomp_zrle.sv | 242 ++++++++++++++++++++++++
 tb/tb_aidc_lite_decomp_zrle.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aidc_lite_zrle_pkg.sv
// Shared constants and types for the ZRLE compressor / decompressor pair.
//   SYM_W         raw symbol width
//   SYMS_PER_BLK  symbols per raw block
//   LIT_TOKEN_W   literal token width {sym, 1'b0}
//   RUN_TOKEN_W   run token width {len[4:0], 1'b1}
//   WORDS_PER_BLK 64b words per raw block
//   WORD_W        bus word width
//   BUF_W         decoder bit-buffer width
package aidc_lite_zrle_pkg;
    localparam int SYM_W         = 32;
    localparam int SYMS_PER_BLK  = 32;
    localparam int LIT_TOKEN_W   = 33;
    localparam int RUN_TOKEN_W   = 6;
    localparam int WORDS_PER_BLK = 16;
    localparam int WORD_W        = 64;
    localparam int BUF_W         = 128;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE,
        FAIL
    } zrle_dec_state_t;
endpackage

// File: rtl/aidc_lite_decomp_zrle_if.sv
// Compressed-word stream into the ZRLE decompressor.
//   valid  word valid
//   sop    first word of block (qualified by valid)
//   eop    last word of block (qualified by valid)
//   data   64b compressed word, bitstream packed LSB-first
//   ready  word accepted when valid & ready
// master = word source, slave = decompressor.
interface aidc_lite_decomp_zrle_if;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [63:0] data;
    logic        ready;

    modport master (output valid, sop, eop, data, input ready);
    modport slave  (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/aidc_lite_zrle_bitbuf.sv
// 128b LSB-first bit accumulator for the ZRLE decoder.
// Per cycle: optional consume of 0/6/33 bits from the bottom, then optional
// append of a 64b word at the (post-consume) fill level. clr_i drops all
// buffered bits before any append in the same cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr_i        discard buffered bits (block restart)
//   append_i     append data_i
//   data_i       64b word to append
//   consume_i    bits to drop from the bottom (0, 6 or 33)
//   head_o       lowest 33 buffered bits (token window)
//   bit_cnt_o    number of valid buffered bits, 0..128
module aidc_lite_zrle_bitbuf
    import aidc_lite_zrle_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   append_i,
    input  logic [WORD_W-1:0]      data_i,
    input  logic [5:0]             consume_i,
    output logic [LIT_TOKEN_W-1:0] head_o,
    output logic [7:0]             bit_cnt_o
);
    logic [BUF_W-1:0] buf_q, buf_d, kept;
    logic [7:0]       bit_cnt_q, bit_cnt_d, kept_cnt;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        kept     = buf_q >> consume_i;
        kept_cnt = bit_cnt_q - {2'b00, consume_i};
        if (clr_i) begin
            kept     = '0;
            kept_cnt = '0;
        end
        buf_d     = kept;
        bit_cnt_d = kept_cnt;
        // Bits above the fill level are always zero, so OR places the word.
        if (append_i) begin
            buf_d     = kept | ({{(BUF_W-WORD_W){1'b0}}, data_i} << kept_cnt);
            bit_cnt_d = kept_cnt + 8'd64;
        end
    end

    // NOTE: state updates use non-blocking <= so all flops sample their
    // inputs before any of them change within the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide buffer is reset on purpose: append relies on the
            // bits above bit_cnt being zero, which a don't-care reset breaks.
            buf_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign head_o    = buf_q[LIT_TOKEN_W-1:0];
    assign bit_cnt_o = bit_cnt_q;
endmodule

// File: rtl/aidc_lite_decomp_zrle.sv
// Zero-run-length decompressor. Consumes one sop/eop framed compressed block
// (token stream: literal {sym[31:0],1'b0} or run {len[4:0],1'b1} = len+1
// zeros) and writes the 32-symbol raw block as 16 x 64b words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   zin             compressed word stream (slave modport)
//   valid_o         raw-buffer write strobe (one cycle per word)
//   addr_o          raw word index 0..15
//   data_o          {sym[2k+1], sym[2k]}
//   done_o / fail_o block status levels, cleared by the next accepted sop
// Optional build macro AIDC_LITE_DECOMP_ZRLE_PERF_EN adds perf_lit_o /
// perf_run_o: saturating literal and run token counts of the current block.
module aidc_lite_decomp_zrle
    import aidc_lite_zrle_pkg::*;
#(
    parameter int MAX_IN_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aidc_lite_decomp_zrle_if.slave zin,
    output logic                  valid_o,
    output logic [3:0]            addr_o,
    output logic [WORD_W-1:0]     data_o,
    output logic                  done_o,
    output logic                  fail_o
`ifdef AIDC_LITE_DECOMP_ZRLE_PERF_EN
    ,
    output logic [5:0]            perf_lit_o,
    output logic [5:0]            perf_run_o
`endif
);
    localparam int                CNT_W   = $clog2(MAX_IN_WORDS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_IN_WORDS);
    localparam logic [5:0]        SYMS    = 6'(SYMS_PER_BLK);

    zrle_dec_state_t    state_q, state_d;
    logic [5:0]         sym_cnt_q, sym_cnt_d;
    logic [5:0]         run_rem_q, run_rem_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic               eop_seen_q, eop_seen_d;
    logic [SYM_W-1:0]   lo_q, lo_d;          // low half of the word being built
    logic               valid_q, valid_d;
    logic [3:0]         addr_q, addr_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    logic [LIT_TOKEN_W-1:0] head;
    logic [7:0]             bit_cnt;
    logic                   buf_clr, buf_append;
    logic [5:0]             buf_consume;

    logic       rdy, accept, sop_acc;
    logic       run_ok, lit_ok;
    logic [5:0] run_len1, sym_left;
    logic       err_size, err_run, err_trunc, err;

    aidc_lite_zrle_bitbuf u_bitbuf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr),
        .append_i  (buf_append),
        .data_i    (zin.data),
        .consume_i (buf_consume),
        .head_o    (head),
        .bit_cnt_o (bit_cnt)
    );

    // Backpressure only while decoding: keep room for a full word after the
    // consume, and stop taking words once the block's eop is in.
    always_comb begin
        rdy = 1'b1;
        if (state_q == DECODE) begin
            rdy = (bit_cnt <= 8'd64) && !eop_seen_q;
        end
    end

    assign zin.ready = rdy;
    assign accept    = zin.valid && rdy;
    assign sop_acc   = accept && zin.sop;

    // A token is only taken once any pending run has been fully emitted.
    assign run_ok   = (run_rem_q == '0) && (bit_cnt >= 8'(RUN_TOKEN_W)) &&  head[0];
    assign lit_ok   = (run_rem_q == '0) && (bit_cnt >= 8'(LIT_TOKEN_W)) && !head[0];
    assign run_len1 = {1'b0, head[5:1]} + 6'd1;
    assign sym_left = SYMS - sym_cnt_q;

    assign err_size  = accept && !zin.sop && (in_cnt_q == MAX_CNT);
    assign err_run   = run_ok && (run_len1 > sym_left);
    assign err_trunc = eop_seen_q && (run_rem_q == '0) && !run_ok && !lit_ok;
    assign err       = err_size || err_run || err_trunc;

    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        run_rem_d   = run_rem_q;
        in_cnt_d    = in_cnt_q;
        eop_seen_d  = eop_seen_q;
        lo_d        = lo_q;
        valid_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        fail_d      = fail_q;
        buf_clr     = 1'b0;
        buf_append  = 1'b0;
        buf_consume = '0;

        if (sop_acc) begin
            // Restart wins over anything the old block was doing this cycle.
            state_d    = DECODE;
            sym_cnt_d  = '0;
            run_rem_d  = '0;
            in_cnt_d   = CNT_W'(1);
            eop_seen_d = zin.eop;
            lo_d       = '0;
            done_d     = 1'b0;
            fail_d     = 1'b0;
            buf_clr    = 1'b1;
            buf_append = 1'b1;
        end else if (state_q == DECODE) begin
            if (accept) begin
                buf_append = 1'b1;
                eop_seen_d = zin.eop;
                if (in_cnt_q != MAX_CNT) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                end
            end

            if (sym_cnt_q == SYMS) begin
                // Last word strobed last cycle; leftover bits are padding.
                state_d = DONE;
                done_d  = 1'b1;
            end else if (err) begin
                state_d = FAIL;
                fail_d  = 1'b1;
            end else if (run_rem_q != '0) begin
                if (!sym_cnt_q[0]) begin
                    lo_d = '0;
                    if (run_rem_q >= 6'd2) begin
                        valid_d   = 1'b1;
                        addr_d    = sym_cnt_q[4:1];
                        data_d    = '0;
                        sym_cnt_d = sym_cnt_q + 6'd2;
                        run_rem_d = run_rem_q - 6'd2;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 6'd1;
                        run_rem_d = run_rem_q - 6'd1;
                    end
                end else begin
                    valid_d   = 1'b1;
                    addr_d    = sym_cnt_q[4:1];
                    data_d    = {{SYM_W{1'b0}}, lo_q};
                    sym_cnt_d = sym_cnt_q + 6'd1;
                    run_rem_d = run_rem_q - 6'd1;
                end
            end else if (run_ok) begin
                run_rem_d   = run_len1;
                buf_consume = 6'(RUN_TOKEN_W);
            end else if (lit_ok) begin
                buf_consume = 6'(LIT_TOKEN_W);
                sym_cnt_d   = sym_cnt_q + 6'd1;
                if (!sym_cnt_q[0]) begin
                    lo_d = head[32:1];
                end else begin
                    valid_d = 1'b1;
                    addr_d  = sym_cnt_q[4:1];
                    data_d  = {head[32:1], lo_q};
                end
            end
        end
        // IDLE / DONE / FAIL: non-sop words are accepted and dropped.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sym_cnt_q  <= '0;
            run_rem_q  <= '0;
            in_cnt_q   <= '0;
            eop_seen_q <= 1'b0;
            lo_q       <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            run_rem_q  <= run_rem_d;
            in_cnt_q   <= in_cnt_d;
            eop_seen_q <= eop_seen_d;
            lo_q       <= lo_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign done_o  = done_q;
    assign fail_o  = fail_q;

`ifdef AIDC_LITE_DECOMP_ZRLE_PERF_EN
    logic [5:0] perf_lit_q, perf_lit_d;
    logic [5:0] perf_run_q, perf_run_d;
    logic       tok_go;

    // A token counts only when the decoder actually consumes it.
    always_comb begin
        tok_go     = (state_q == DECODE) && !sop_acc && (sym_cnt_q != SYMS) && !err;
        perf_lit_d = perf_lit_q;
        perf_run_d = perf_run_q;
        if (sop_acc) begin
            perf_lit_d = '0;
            perf_run_d = '0;
        end else if (tok_go && lit_ok && (perf_lit_q != 6'd63)) begin
            perf_lit_d = perf_lit_q + 6'd1;
        end else if (tok_go && run_ok && (perf_run_q != 6'd63)) begin
            perf_run_d = perf_run_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lit_q <= '0;
            perf_run_q <= '0;
        end else begin
            perf_lit_q <= perf_lit_d;
            perf_run_q <= perf_run_d;
        end
    end

    assign perf_lit_o = perf_lit_q;
    assign perf_run_o = perf_run_q;
`endif
endmodule

// File: tb/tb_aidc_lite_decomp_zrle.sv
// Self-checking bench for aidc_lite_decomp_zrle. A bit-level token parser
// builds the expected raw words and final status per block; expected writes
// are queued when a block is issued and a monitor pops them on valid_o.
module tb_aidc_lite_decomp_zrle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aidc_lite_decomp_zrle_if zin();

    logic        valid_o;
    logic [3:0]  addr_o;
    logic [63:0] data_o;
    logic        done_o;
    logic        fail_o;
`ifdef AIDC_LITE_DECOMP_ZRLE_PERF_EN
    logic [5:0]  perf_lit_o;
    logic [5:0]  perf_run_o;
`endif

    aidc_lite_decomp_zrle #(.MAX_IN_WORDS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .zin     (zin),
        .valid_o (valid_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .fail_o  (fail_o)
`ifdef AIDC_LITE_DECOMP_ZRLE_PERF_EN
        ,
        .perf_lit_o (perf_lit_o),
        .perf_run_o (perf_run_o)
`endif
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    bit          bs [0:2047];
    int          bs_len;
    logic [63:0] blk [0:31];
    logic [31:0] ref_syms [0:31];
    int          ref_nsym;
    bit          ref_ok;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write", addr_o, data_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(addr_o), 64'(e.addr));
                check("wr_data", data_o, e.data);
            end
        end
    end

    // ---------------- bitstream builder ----------------
    task automatic put_lit(input logic [31:0] v);
        bs[bs_len] = 1'b0;
        for (int i = 0; i < 32; i++) bs[bs_len + 1 + i] = v[i];
        bs_len += 33;
    endtask

    task automatic put_run(input int len1);
        logic [4:0] l;
        l = 5'(len1 - 1);
        bs[bs_len] = 1'b1;
        for (int i = 0; i < 5; i++) bs[bs_len + 1 + i] = l[i];
        bs_len += 6;
    endtask

    task automatic pack(output int n);
        n = (bs_len + 63) / 64;
        for (int i = 0; i < 32; i++) blk[i] = '0;
        for (int i = 0; i < bs_len; i++) blk[i / 64][i % 64] = bs[i];
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] field(input int p, input int w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v[i] = blk[(p + i) / 64][(p + i) % 64];
        return v;
    endfunction

    // Parse the concatenated words as a token stream; stop on a token that
    // does not fit in the remaining bits or a run that overshoots 32 symbols.
    task automatic model_block(input int n);
        int total;
        int p;
        int len1;
        total    = n * 64;
        p        = 0;
        ref_nsym = 0;
        while (ref_nsym < 32 && p < total) begin
            if (field(p, 1) == 32'd1) begin
                if (p + 6 > total) break;
                len1 = int'(field(p + 1, 5)) + 1;
                if (len1 > 32 - ref_nsym) break;
                for (int k = 0; k < len1; k++) ref_syms[ref_nsym + k] = '0;
                ref_nsym += len1;
                p += 6;
            end else begin
                if (p + 33 > total) break;
                ref_syms[ref_nsym] = field(p + 1, 32);
                ref_nsym += 1;
                p += 33;
            end
        end
        ref_ok = (ref_nsym == 32) && (n <= 16);
    endtask

    task automatic push_writes(input int nsym);
        wr_t e;
        for (int k = 0; k < nsym / 2; k++) begin
            e.addr = 4'(k);
            e.data = {ref_syms[2 * k + 1], ref_syms[2 * k]};
            exp_q.push_back(e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_word(input logic [63:0] d, input bit sop, input bit eop, input int gap);
        bit ok;
        repeat (gap) @(negedge clk);
        zin.valid = 1'b1;
        zin.sop   = sop;
        zin.eop   = eop;
        zin.data  = d;
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            ok = (zin.ready === 1'b1);
            @(negedge clk);
        end
        zin.valid = 1'b0;
        zin.sop   = 1'b0;
        zin.eop   = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready low for 1000 cycles, expected acceptance");
        end
    endtask

    task automatic run_block(input int n, input int max_gap);
        int  gap;
        bit  seen;
        model_block(n);
        push_writes(ref_nsym);
        for (int i = 0; i < n; i++) begin
            gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
            send_word(blk[i], i == 0, i == n - 1, gap);
            if (i == 0) begin
                check("sop_clears_done", 64'(done_o), 64'd0);
                check("sop_clears_fail", 64'(fail_o), 64'd0);
            end
            if (i == 1 && gap == 0) check("ready_throttle", 64'(zin.ready), 64'd0);
            if (i == 16) check("size_limit_fail", 64'(fail_o), 64'd1);
        end
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            if (done_o === 1'b1 || fail_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL status_timeout: got neither done nor fail, expected one");
        end
        check("done", 64'(done_o), 64'(ref_ok));
        check("fail", 64'(fail_o), 64'(!ref_ok));
        repeat (4) @(negedge clk);
        if (n <= 16) check("writes_outstanding", 64'(exp_q.size()), 64'd0);
        else exp_q.delete();
    endtask

    task automatic gen_random_block(input int mode, output int n);
        int syms;
        int len1;
        bs_len = 0;
        syms   = 0;
        while (syms < 32) begin
            if ($urandom_range(1, 0) == 1 && bs_len + 33 <= 990) begin
                put_lit(($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom));
                syms++;
            end else begin
                if (bs_len + 33 > 990) len1 = 32 - syms;
                else len1 = $urandom_range(32 - syms, 1);
                put_run(len1);
                syms += len1;
            end
        end
        if (mode == 1 && bs_len > 2) bs_len = $urandom_range(bs_len - 1, 1);
        if (mode == 2) begin
            int b;
            b = $urandom_range(bs_len - 1, 0);
            bs[b] = !bs[b];
        end
        pack(n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        zin.valid = 1'b0;
        zin.sop   = 1'b0;
        zin.eop   = 1'b0;
        zin.data  = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_addr",  64'(addr_o),  64'd0);
        check("rst_data",  data_o,       64'd0);
        check("rst_done",  64'(done_o),  64'd0);
        check("rst_fail",  64'(fail_o),  64'd0);
        check("rst_ready", 64'(zin.ready), 64'd1);

        // Non-sop word while idle must be dropped.
        send_word(64'h3F, 1'b0, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("idle_drop_done", 64'(done_o), 64'd0);
        check("idle_drop_fail", 64'(fail_o), 64'd0);

        // 1: all-zero block via one run of 32
        for (int i = 0; i < 32; i++) blk[i] = '0;
        blk[0] = 64'h3F;
        run_block(1, 0);

        // 2: literal 1 then run 31
        blk[0] = 64'h0000_007A_0000_0002;
        run_block(1, 0);

        // 3: run overflow after one literal
        bs_len = 0;
        put_lit(32'hDEAD_BEEF);
        put_run(32);
        pack(n);
        run_block(n, 0);

        // 4: truncation after 10 literals
        bs_len = 0;
        for (int i = 0; i < 10; i++) put_lit(32'($urandom));
        pack(n);
        run_block(n, 2);

        // 5: 32 literals need 17 words
        bs_len = 0;
        for (int i = 0; i < 32; i++) put_lit(32'($urandom));
        pack(n);
        run_block(n, 0);

        // 6: restart mid-block, then the all-zero block
        bs_len = 0;
        for (int i = 0; i < 6; i++) put_lit(32'($urandom));
        pack(n);
        model_block(3);
        push_writes(ref_nsym);
        for (int i = 0; i < 3; i++) send_word(blk[i], i == 0, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("partial_writes", 64'(exp_q.size()), 64'd0);
        check("partial_done", 64'(done_o), 64'd0);
        check("partial_fail", 64'(fail_o), 64'd0);
        for (int i = 0; i < 32; i++) blk[i] = '0;
        blk[0] = 64'h3F;
        run_block(1, 0);

        // Randomised blocks: clean, truncated, and bit-corrupted streams.
        for (int r = 0; r < 30; r++) begin
            gen_random_block($urandom_range(2, 0), n);
            run_block(n, (r % 3 == 0) ? 0 : 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
